uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_transmitter between N byte-producing requesters. It captures the winning requester's byte and pulses the transmitter write strobe. It then tracks the transmitter's busy flag through the whole frame before granting again. Optional packet lock keeps the grant on one requester until that requester marks a byte as last.

Parameters:
N, 4, number of requesters (2..8)
OWNER_W, 2, width of owner index; must be >= clog2(N)
START_TIMEOUT, 64, cycles allowed between tx_wr_en and tx_busy rising before abort

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
req  input  N  per-requester byte request; hold high with stable data until ack
req_data  input  8*N  byte of requester i on bits [8i+7:8i]
req_last  input  N  byte of requester i ends its packet (releases lock)
ack  output  N  one-cycle pulse: byte of requester i handed to transmitter
tx_wr_en  output  1  write strobe to transmitter (one-cycle pulse)
tx_data  output  8  byte to transmitter, registered
tx_busy  input  1  transmitter busy flag
owner  output  OWNER_W  index of current/last granted requester
active  output  1  high from grant until frame complete (state != IDLE)
err_timeout  output  1  one-cycle pulse on start timeout

Behaviour:
- Reset (rst=0, async): state IDLE; ack=0, tx_wr_en=0, tx_data=0, owner=0, active=0, err_timeout=0; rr pointer=0; lock cleared; timer=0.
- States: IDLE, LOAD, WAIT_START, WAIT_END.
- IDLE: grants only when tx_busy=0 and |req=1.
  - Locked and req[owner]=1: winner=owner.
  - Locked and req[owner]=0: lock cleared; normal arbitration in the same cycle.
  - Unlocked: winner is the first asserted req scanning ptr, ptr+1, ..., wrapping modulo N.
  - On grant: tx_data<=winner slice, owner<=winner, captured_last<=req_last[winner], ptr<=(winner+1) mod N; next state LOAD.
- LOAD (1 cycle): tx_wr_en=1 and ack[owner]=1 in the same cycle; timer<=0; next state WAIT_START.
- WAIT_START:
  - tx_busy=1: next state WAIT_END.
  - Otherwise timer increments. When timer==START_TIMEOUT-1 with tx_busy still 0: err_timeout=1 for one cycle, lock cleared, next state IDLE. The byte is considered lost; no retry.
- WAIT_END: tx_busy=0 leads to IDLE. On exit, lock<=~captured_last (lock set to owner if the byte was not last).
- Latency: grant-to-tx_wr_en is 1 cycle. The earliest next grant is the cycle after tx_busy falls, because IDLE rechecks tx_busy.
- A requester never receives two acks for one request. It must drop req, or present a new byte, in the cycle after ack.
- A req that falls after the IDLE grant but before ack is a protocol violation. The captured byte is still sent and ack still pulses.
- tx_busy already high in IDLE (external writer): no grant until it falls.
- Simultaneous requests: only one ack per frame, by round-robin order. A losing requester waits at most N-1 frames, unless a lock holder keeps streaming; lock starvation is by design.
- Only tx_wr_en, ack and err_timeout are pulses. owner holds its value in IDLE.

Test Plan:
- Single requester: req[2]=1, data 0xA5, last=1; tx_busy model rises 2 cycles after strobe and stays high 10 cycles -> ack[2] and tx_wr_en coincide one cycle after req is seen; tx_data=0xA5; no second strobe until tx_busy=0.
- Fairness: req[0], req[1] and req[3] held continuously with last=1 after reset -> grant order 0,1,3,0,1,3; exactly one ack per frame.
- Packet lock: requester 1 sends 0x11 (last=0), 0x22 (last=0), 0x33 (last=1) while req[0] is also high -> order 0x11, 0x22, 0x33, then requester 0.
- Lock release by drop: requester 2 sends a last=0 byte, then drops req while req[3]=1 -> requester 3 is granted next frame; lock is cleared.
- Timeout: tx_busy tied 0, START_TIMEOUT=8 -> err_timeout pulses exactly 8 cycles after tx_wr_en; state returns to IDLE; the next request is granted normally.
- Async reset in WAIT_END: assert rst=0 mid-frame -> all outputs 0 immediately without a clock edge; after release, ptr=0, so requester 0 wins a tie with requester 1.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/transmitter signal bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int N       = 4,
  parameter int OWNER_W = 2
);
  logic [N-1:0]       req;
  logic [8*N-1:0]     req_data;
  logic [N-1:0]       req_last;
  logic [N-1:0]       ack;
  logic               tx_wr_en;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic [OWNER_W-1:0] owner;
  logic               active;
  logic               err_timeout;

  modport slave (
    input  req, req_data, req_last, tx_busy,
    output ack, tx_wr_en, tx_data, owner, active, err_timeout
  );

  modport master (
    output req, req_data, req_last, tx_busy,
    input  ack, tx_wr_en, tx_data, owner, active, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N byte requesters
// Tracks tx_busy through each frame; optional packet lock holds the grant until a last byte.
module uart_tx_arbiter #(
  parameter int N             = 4,
  parameter int OWNER_W       = 2,
  parameter int START_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int TIMER_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_END} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       ack_q, ack_d;
  logic               tx_wr_en_q, tx_wr_en_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic               active_q, active_d;
  logic               lock_q, lock_d;
  logic               last_q, last_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic               rr_found;
  logic [OWNER_W-1:0] rr_winner;
  logic               lock_hit;
  logic               grant;
  logic [OWNER_W-1:0] winner;
  logic [IDX_W-1:0]   winner_idx;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic [N-1:0]       sel_onehot;
  logic [OWNER_W-1:0] ptr_next;

  // Scan ptr, ptr+1, ... modulo N; the first asserted request wins.
  always_comb begin : rr_scan
    logic [IDX_W-1:0] idx;
    rr_found  = 1'b0;
    rr_winner = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDX_W'((int'(ptr_q) + i) % N);
      if (!rr_found && bus.req[idx]) begin
        rr_found  = 1'b1;
        rr_winner = OWNER_W'(idx);
      end
    end
  end

  // A held lock only wins while its owner keeps requesting; otherwise it dissolves into round-robin.
  assign lock_hit   = lock_q && bus.req[IDX_W'(owner_q)];
  assign grant      = !bus.tx_busy && rr_found;
  assign winner     = lock_hit ? owner_q : rr_winner;
  assign winner_idx = IDX_W'(winner);
  assign ptr_next   = (int'(winner) + 1 == N) ? '0 : winner + 1'b1;

  always_comb begin : winner_mux
    sel_data   = '0;
    sel_last   = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) == winner_idx) begin
        sel_data      = bus.req_data[i*8 +: 8];
        sel_last      = bus.req_last[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    ack_d      = '0;
    tx_wr_en_d = 1'b0;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    active_d   = active_q;
    lock_d     = lock_q;
    last_d     = last_q;
    timer_d    = timer_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          tx_data_d  = sel_data;
          owner_d    = winner;
          last_d     = sel_last;
          ptr_d      = ptr_next;
          lock_d     = lock_hit;
          ack_d      = sel_onehot;
          tx_wr_en_d = 1'b1;
          active_d   = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        timer_d = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (bus.tx_busy) begin
          state_d = WAIT_END;
        end else if (timer_q == TIMER_LAST) begin
          // The byte is abandoned: no retry, and any packet lock is dropped.
          lock_d   = 1'b0;
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_END: begin
        if (!bus.tx_busy) begin
          lock_d   = ~last_q;
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      tx_wr_en_q <= 1'b0;
      tx_data_q  <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      active_q   <= 1'b0;
      lock_q     <= 1'b0;
      last_q     <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      tx_wr_en_q <= tx_wr_en_d;
      tx_data_q  <= tx_data_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      active_q   <= active_d;
      lock_q     <= lock_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.tx_wr_en    = tx_wr_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.owner       = owner_q;
  assign bus.active      = active_q;
  // Flagged in the final allowed cycle itself, so the pulse lands START_TIMEOUT cycles after the strobe.
  assign bus.err_timeout = (state_q == WAIT_START) && !bus.tx_busy && (timer_q == TIMER_LAST);
endmodule
